// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, line levels and bit-timing helpers.
// Imported by the receiver and its synchroniser; the line-level constants match the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_rx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

    // Offset from a bit edge to its centre, in clk cycles.
    function automatic int half_bit(input int divisor);
        return divisor / 2;
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level
// so a reset never looks like a start bit.
module uart_sync2
    import uart_pkg::*;
(
    input  logic clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = i_d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            meta_q <= UART_IDLE_LEVEL;
            sync_q <= UART_IDLE_LEVEL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, WIDTH data bits LSB first (WIDTH >= 2), 1 stop; oversampled on clk.
// Define UART_RX_MAJORITY_EN to take a 3-sample majority vote around each bit centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DIVISOR = 100
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_dv,
    output logic             o_frame_err,
    output logic             o_busy
);

    localparam int CNT_W    = $clog2(DIVISOR);
    localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HALF_BIT = half_bit(DIVISOR);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after the centre, so the start decision lands one cycle
    // later; every later bit is then counted from that shifted origin.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF_BIT);
`else
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(HALF_BIT - 1);
`endif

    logic rx_s;
    logic sample;

    uart_rx_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dv_q, dv_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;

    uart_sync2 u_sync (
        .clk     (clk),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rx_s};
        sample = maj3(rx_s, hist_q[0], hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (i_reset) hist_q <= {2{UART_IDLE_LEVEL}};
        else         hist_q <= hist_d;
    end
`else
    assign sample = rx_s;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (rx_s == UART_START_LEVEL) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_START) begin
                    cnt_d   = '0;
                    state_d = (sample == UART_START_LEVEL) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {sample, shreg_q[WIDTH-1:1]};
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sample == UART_IDLE_LEVEL) begin
                        data_d  = shreg_q;
                        dv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low break must not retrigger; wait for the line to recover.
                cnt_d = '0;
                if (rx_s == UART_IDLE_LEVEL) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_START) || (state_d == ST_DATA) || (state_d == ST_STOP);
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign o_data      = data_q;
    assign o_dv        = dv_q;
    assign o_frame_err = ferr_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx (WIDTH=8, DIVISOR=16): a behavioural transmitter drives i_rx
// and queues the expected event; a negedge monitor pops and compares on each o_dv / o_frame_err.
module tb_uart_rx;

    localparam int W = 8;
    localparam int D = 16;
    localparam int H = D / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT = 156;
`else
    localparam int LAT = 155;
`endif

    logic         clk = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_rx = 1'b1;
    logic [W-1:0] o_data;
    logic         o_dv;
    logic         o_frame_err;
    logic         o_busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         start;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    uart_rx #(.WIDTH(W), .DIVISOR(D)) dut (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_dv        (o_dv),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every output event must match the oldest queued expectation.
    always @(negedge clk) begin
        if (o_dv === 1'b1 || o_frame_err === 1'b1) begin
            chk("dv_err_overlap", {31'd0, o_dv & o_frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {30'd0, o_dv, o_frame_err}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("event_kind", {31'd0, o_frame_err}, {31'd0, e.is_err});
                chk("event_data", {24'd0, o_data}, {24'd0, e.data});
                if (e.lat != 0) chk("dv_latency", cyc - e.start, e.lat);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bitd(input logic b, input int n);
        i_rx = b;
        tick(n);
    endtask

    task automatic gbit(input logic b, input bit glitch);
        if (glitch) begin
            bitd(b, H);
            bitd(~b, 1);
            bitd(b, D - H - 1);
        end else begin
            bitd(b, D);
        end
    endtask

    task automatic push(input bit is_err, input logic [7:0] d, input int lat);
        exp_t x;
        x.is_err = is_err;
        x.data   = d;
        x.start  = cyc;
        x.lat    = lat;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic [7:0] d, input bit glitch);
        gbit(1'b0, glitch);
        for (int i = 0; i < W; i++) gbit(d[i], glitch);
        gbit(1'b1, glitch);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_data"},  {24'd0, o_data}, 32'd0);
        chk({tag, "_dv"},    {31'd0, o_dv}, 32'd0);
        chk({tag, "_ferr"},  {31'd0, o_frame_err}, 32'd0);
        chk({tag, "_busy"},  {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        logic [7:0] v;

        tick(4);
        @(negedge clk);
        chk_idle_outputs("reset");
        tick(1);
        i_reset = 1'b0;
        tick(2 * D);

        // Loopback of a single word
        push(1'b0, 8'hA5, LAT);
        send(8'hA5, 1'b0);
        tick(2 * D);

        // False start: 4-cycle low pulse
        bitd(1'b0, 4);
        i_rx = 1'b1;
        @(negedge clk);
        chk("busy_false_start", {31'd0, o_busy}, 32'd1);
        tick(2 * D);
        @(negedge clk);
        chk("busy_after_false_start", {31'd0, o_busy}, 32'd0);
        tick(1);
        push(1'b0, 8'h3C, LAT);
        send(8'h3C, 1'b0);
        tick(2 * D);

        // Framing error: stop bit low, line held low ~5 bit times
        v = 8'h5A;
        push(1'b1, 8'h3C, 0);
        bitd(1'b0, D);
        for (int i = 0; i < W; i++) bitd(v[i], D);
        bitd(1'b0, 3 * D);
        @(negedge clk);
        chk("busy_wait_high", {31'd0, o_busy}, 32'd0);
        tick(1);
        bitd(1'b0, 2 * D);
        bitd(1'b1, 2 * D);
        push(1'b0, 8'h81, LAT);
        send(8'h81, 1'b0);
        tick(2 * D);

        // Back-to-back frames, no idle gap
        push(1'b0, 8'h00, LAT);
        send(8'h00, 1'b0);
        push(1'b0, 8'hFF, LAT);
        send(8'hFF, 1'b0);
        push(1'b0, 8'h55, LAT);
        send(8'h55, 1'b0);
        tick(2 * D);

        // Reset during data bit 4; the transmitter abandons the frame too
        v = 8'hC3;
        bitd(1'b0, D);
        for (int i = 0; i < 4; i++) bitd(v[i], D);
        bitd(v[4], H);
        i_reset = 1'b1;
        i_rx    = 1'b1;
        tick(1);
        i_reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("mid_reset");
        tick(2 * D);
        push(1'b0, 8'h12, LAT);
        send(8'h12, 1'b0);
        tick(2 * D);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle glitch at every bit centre must be voted out
        push(1'b0, 8'h96, LAT);
        send(8'h96, 1'b1);
        tick(2 * D);
`endif

        for (int i = 0; i < 20 * D && exp_q.size() != 0; i++) tick(1);
        chk("pending_events", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
